// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative square-root engine.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Low two bits of the trial divisor {root, 01} in each recurrence step.
  localparam logic [1:0] TRIAL_SUFFIX = 2'b01;

  // Root width for a given radicand width.
  function automatic int root_w(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One radix-2 restoring square-root iteration: brings down two radicand
// bits, tries the divisor {root, 01} and yields the next root bit.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int RW = 8
) (
  input  logic [RW+1:0] rem_in,
  input  logic [1:0]    rad_bits,
  input  logic [RW-1:0] root_in,
  output logic [RW+1:0] rem_out,
  output logic          root_bit
);

  logic [RW+1:0] shifted;
  logic [RW+1:0] trial;

  // Before any step the partial remainder is at most 2*root < 2^RW, so its
  // two top bits are always zero and the shifted value still fits RW+2 bits.
  logic unused_rem_hi;
  assign unused_rem_hi = ^rem_in[RW+1:RW];

  // Compare-and-subtract for a single root bit.
  always_comb begin
    shifted  = {rem_in[RW-1:0], rad_bits};
    trial    = {root_in, TRIAL_SUFFIX};
    root_bit = (shifted >= trial);
    rem_out  = root_bit ? (shifted - trial) : shifted;
  end

endmodule

// File: rtl/sqrt_iter.sv
// Sequential integer square root: one root bit per clock, floor remainder,
// optional round-to-nearest with saturation, valid/ready on both sides.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_root,
  output logic [WIDTH/2:0]   out_rem,
  output logic               out_sat
);

  localparam int RW = root_w(WIDTH);
  localparam int CW = $clog2(RW + 1);

  generate
    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
      $fatal(1, "sqrt_iter: WIDTH must be even and >= 4");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   out_root_q, out_root_d;
  logic [RW:0]     out_rem_q, out_rem_d;
  logic            out_sat_q, out_sat_d;

  logic [WIDTH-1:0] rad_q, rad_d;
  logic [RW+1:0]    rem_q, rem_d;
  logic [RW-1:0]    root_q, root_d;
  logic             round_q, round_d;

  logic [RW+1:0]    step_rem;
  logic             step_bit;
  logic [RW-1:0]    root_next;

  // Round-up happens when rem > root (sqrt(x) >= root + 0.5); an all-ones
  // root cannot grow, so it is held at all-ones and flagged. Returns {sat, root}.
  function automatic logic [RW:0] round_sat(input logic [RW-1:0] root,
                                            input logic [RW+1:0] rem,
                                            input logic          rnd);
    if (rnd && (rem > {2'b00, root})) begin
      if (&root) return {1'b1, {RW{1'b1}}};
      return {1'b0, root + RW'(1)};
    end
    return {1'b0, root};
  endfunction

  sqrt_step #(.RW(RW)) u_step (
    .rem_in   (rem_q),
    .rad_bits (rad_q[WIDTH-1 -: 2]),
    .root_in  (root_q),
    .rem_out  (step_rem),
    .root_bit (step_bit)
  );

  assign root_next = {root_q[RW-2:0], step_bit};

  // Next-state, datapath and output logic for IDLE -> CALC -> DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    out_root_d  = out_root_q;
    out_rem_d   = out_rem_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          rad_d   = in_data;
          round_d = in_round;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(RW);
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = root_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d                 = DONE;
          out_valid_d             = 1'b1;
          out_rem_d               = step_rem[RW:0];
          {out_sat_d, out_root_d} = round_sat(root_next, step_rem, round_q);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Control and visible outputs: synchronous reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_root_q  <= out_root_d;
      out_rem_q   <= out_rem_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Working registers; always reloaded on accept, so no reset needed.
  always_ff @(posedge clk) begin
    rad_q   <= rad_d;
    rem_q   <= rem_d;
    root_q  <= root_d;
    round_q <= round_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Self-checking bench for sqrt_iter (WIDTH=16): directed cases, back-pressure,
// mid-operation reset and a randomized sweep against a behavioural model.
module tb_sqrt_iter;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_round;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_root;
  logic [RW:0]       out_rem;
  logic              out_sat;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_rem   (out_rem),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor root by search, round-up iff 4x >= (2r+1)^2,
  // saturate when the rounded root no longer fits RW bits.
  function automatic void ref_model(input int x, input bit rnd,
                                    output int root, output int rem, output bit sat);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    rem  = x - r * r;
    root = r;
    sat  = 1'b0;
    if (rnd && (4 * x >= (2 * r + 1) * (2 * r + 1))) begin
      if (r + 1 == (1 << RW)) begin
        root = (1 << RW) - 1;
        sat  = 1'b1;
      end else begin
        root = r + 1;
      end
    end
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] x, input logic rnd,
                        input int er, input int erem, input logic esat,
                        input int hold, input string tag);
    int n;
    int waitc;
    logic [31:0] snap;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = x;
    in_round = rnd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_round = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    chk({tag, "_latency"}, n, RW);
    chk({tag, "_root"}, out_root, er);
    chk({tag, "_rem"}, out_rem, erem);
    chk({tag, "_sat"}, out_sat, esat);
    snap = {13'd0, out_valid, in_ready, out_sat, out_rem, out_root};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_data  = WIDTH'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold"}, {13'd0, out_valid, in_ready, out_sat, out_rem, out_root}, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release"}, out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int rm;
    bit s;
    int x;
    bit rnd;
    int waitc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_round  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_sat, out_rem, out_root}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    run_op(16'd144,   1'b0, 12,  0,   1'b0, 0, "sq144");
    run_op(16'd150,   1'b1, 12,  6,   1'b0, 0, "r150");
    run_op(16'd157,   1'b1, 13,  13,  1'b0, 0, "r157");
    run_op(16'd65535, 1'b0, 255, 510, 1'b0, 0, "max_floor");
    run_op(16'd65535, 1'b1, 255, 510, 1'b1, 0, "max_round");
    run_op(16'd0,     1'b0, 0,   0,   1'b0, 0, "zero");
    run_op(16'd1,     1'b0, 1,   0,   1'b0, 0, "one");
    run_op(16'd1000,  1'b0, 31,  39,  1'b0, 20, "backpressure");

    // Reset in the middle of CALC must wipe everything on the next edge.
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    in_valid = 1'b1;
    in_data  = 16'd40000;
    in_round = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_outputs", {out_sat, out_rem, out_root}, 0);
    rst = 1'b0;
    run_op(16'd49, 1'b0, 7, 0, 1'b0, 0, "after_rst");

    // Randomized sweep against the reference model.
    for (int k = 0; k < 2500; k++) begin
      x   = (k % 10 == 0) ? int'($urandom_range(255, 0)) * int'($urandom_range(255, 0))
                          : int'($urandom_range(65535, 0));
      rnd = 1'($urandom);
      ref_model(x, rnd, r, rm, s);
      run_op(WIDTH'(x), rnd, r, rm, s, int'($urandom_range(2, 0)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
